// File: rtl/loss_pkg.sv
// Shared types and width helpers for the squared-error loss accumulator.
package loss_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Width of predicted - target: one guard bit above the prediction width.
    function automatic int diff_w(input int pred_w);
        return pred_w + 1;
    endfunction

    // Width of the exact square of the difference.
    function automatic int sq_w(input int pred_w);
        return 2 * pred_w;
    endfunction

endpackage

// File: rtl/sq_err_stage.sv
// Two-stage squared-error pipeline: S1 registers the difference, S2 its square.
// Valid bits travel with the data; clr_i drops anything in flight.
module sq_err_stage import loss_pkg::*; #(
    parameter int TGT_W  = 4,
    parameter int PRED_W = 23
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clr_i,
    input  logic                      v_i,
    input  logic [TGT_W-1:0]          target_i,
    input  logic [PRED_W-1:0]         predicted_i,
    output logic                      v_o,
    output logic [sq_w(PRED_W)-1:0]   sq_o
);

    localparam int DW   = diff_w(PRED_W);
    localparam int SQ_W = sq_w(PRED_W);

    logic                  v1_q;
    logic signed [DW-1:0]  diff_d;
    logic signed [DW-1:0]  diff_q;
    logic [SQ_W-1:0]       diff_x;
    logic [SQ_W-1:0]       sq_d;

    // |diff| < 2^PRED_W, so the square modulo 2^SQ_W is the exact square.
    assign diff_d = $signed({predicted_i[PRED_W-1], predicted_i})
                  - $signed({{(DW-TGT_W){1'b0}}, target_i});
    assign diff_x = {{(SQ_W-DW){diff_q[DW-1]}}, diff_q};
    assign sq_d   = diff_x * diff_x;

    // Pipeline registers with their valid bits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            v1_q   <= 1'b0;
            v_o    <= 1'b0;
            diff_q <= '0;
            sq_o   <= '0;
        end else if (clr_i) begin
            v1_q   <= 1'b0;
            v_o    <= 1'b0;
        end else begin
            v1_q <= v_i;
            v_o  <= v1_q;
            if (v_i)  diff_q <= diff_d;
            if (v1_q) sq_o   <= sq_d;
        end
    end

endmodule

// File: rtl/loss_accum.sv
// Streaming squared-error loss accumulator: squares (predicted - target) per
// sample and sums the squares over a batch, returned over valid/ready.
// Build option LOSS_ACC_SAT_EN: accumulator clamps at all-ones on overflow
// instead of wrapping. ovf_o flags the overflow in both builds.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no batch open; first accepted sample starts a new one
// ACCUM | batch open, accepting samples
// DRAIN | batch closed, waiting for in-flight squares to reach acc
// HOLD  | result presented on loss_o/count_o/ovf_o until out_ready_i
module loss_accum import loss_pkg::*; #(
    parameter int TGT_W  = 4,
    parameter int PRED_W = 23,
    parameter int BATCH  = 8,
    parameter int ACC_W  = 2*PRED_W + $clog2(BATCH),
    parameter int CNT_W  = $clog2(BATCH+1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clr_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_last_i,
    input  logic [TGT_W-1:0]   target_i,
    input  logic [PRED_W-1:0]  predicted_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ACC_W-1:0]   loss_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               ovf_o
);

    localparam int SQ_W  = sq_w(PRED_W);
    localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

    state_t              state_q, state_d;
    logic                accept;
    logic                closes;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    count_q;
    logic [ACC_W-1:0]    acc_q;
    logic [ACC_W-1:0]    acc_nxt;
    logic [ACC_W-1:0]    loss_q;
    logic                ovf_q;
    logic [1:0]          drain_q;
    logic                sq_v;
    logic [SQ_W-1:0]     sq;
    logic [SUM_W-1:0]    sum;
    logic                carry;

    sq_err_stage #(
        .TGT_W  (TGT_W),
        .PRED_W (PRED_W)
    ) u_sq_err (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .v_i         (accept),
        .target_i    (target_i),
        .predicted_i (predicted_i),
        .v_o         (sq_v),
        .sq_o        (sq)
    );

    assign in_ready_o  = ((state_q == IDLE) || (state_q == ACCUM)) && !clr_i;
    assign out_valid_o = (state_q == HOLD);
    assign accept      = in_valid_i & in_ready_o;

    // The first accept of a batch counts as sample 1 whatever count_q holds.
    assign cnt_inc = (state_q == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
    assign closes  = in_last_i | (cnt_inc == CNT_W'(BATCH));

    assign sum   = SUM_W'(acc_q) + SUM_W'(sq);
    assign carry = |sum[SUM_W-1:ACC_W];
`ifdef LOSS_ACC_SAT_EN
    assign acc_nxt = carry ? '1 : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    assign loss_o  = loss_q;
    assign count_o = count_q;
    assign ovf_o   = ovf_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; clr_i overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = closes ? DRAIN : ACCUM;
            ACCUM:   if (accept && closes) state_d = DRAIN;
            DRAIN:   if (drain_q == 2'd0) state_d = HOLD;
            HOLD:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clr_i) state_d = IDLE;
    end

    // Counter, accumulator, drain timer and result register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            drain_q <= 2'd0;
            loss_q  <= '0;
        end else if (clr_i) begin
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            drain_q <= 2'd0;
            loss_q  <= '0;
        end else begin
            if (sq_v) begin
                acc_q <= acc_nxt;
                if (carry) ovf_q <= 1'b1;
            end
            if (accept) begin
                count_q <= cnt_inc;
                // Two more edges bring the closing sample through S2 into acc.
                if (closes) drain_q <= 2'd2;
                if (state_q == IDLE) begin
                    acc_q <= '0;
                    ovf_q <= 1'b0;
                end
            end
            if (state_q == DRAIN) begin
                if (drain_q != 2'd0) drain_q <= drain_q - 2'd1;
                else                 loss_q  <= acc_q;
            end
        end
    end

endmodule

// File: tb/tb_loss_accum.sv
// Randomized self-checking bench for loss_accum (BATCH=4, ACC_W=8 so that
// overflow is reachable). The expected result of each batch is derived from
// the exact sum of squares; build with LOSS_ACC_SAT_EN to check clamping.
`timescale 1ns/1ps
module tb_loss_accum;

    localparam int TGT_W  = 4;
    localparam int PRED_W = 23;
    localparam int BATCH  = 4;
    localparam int ACC_W  = 8;
    localparam int CNT_W  = $clog2(BATCH+1);

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b0;
    logic               clr_i = 1'b0;
    logic               in_valid_i = 1'b0;
    logic               in_ready_o;
    logic               in_last_i = 1'b0;
    logic [TGT_W-1:0]   target_i = '0;
    logic [PRED_W-1:0]  predicted_i = '0;
    logic               out_valid_o;
    logic               out_ready_i = 1'b0;
    logic [ACC_W-1:0]   loss_o;
    logic [CNT_W-1:0]   count_o;
    logic               ovf_o;

    loss_accum #(
        .TGT_W  (TGT_W),
        .PRED_W (PRED_W),
        .BATCH  (BATCH),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (clr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_last_i   (in_last_i),
        .target_i    (target_i),
        .predicted_i (predicted_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .loss_o      (loss_o),
        .count_o     (count_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    logic [PRED_W-1:0] b_pred [BATCH];
    logic [TGT_W-1:0]  b_tgt  [BATCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Exact sum of squared errors over the first n samples of the batch.
    function automatic longint model_total(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) begin
            longint d = longint'($signed(b_pred[i])) - longint'(b_tgt[i]);
            s += d * d;
        end
        return s;
    endfunction

    function automatic longint model_loss(input longint s);
        longint lim = longint'(1) << ACC_W;
`ifdef LOSS_ACC_SAT_EN
        return (s >= lim) ? lim - 1 : s;
`else
        return s % lim;
`endif
    endfunction

    function automatic longint model_ovf(input longint s);
        return (s >= (longint'(1) << ACC_W)) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present n samples from the batch arrays, with up to max_gap idle cycles before each.
    task automatic send(input int n, input bit last_at_end, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (g) tick();
            in_valid_i  = 1'b1;
            predicted_i = b_pred[i];
            target_i    = b_tgt[i];
            in_last_i   = last_at_end && (i == n - 1);
            chk("in_ready_accum", 64'(in_ready_o), 64'd1);
            tick();
            in_valid_i = 1'b0;
            in_last_i  = 1'b0;
        end
    endtask

    // Called right after the closing accept: checks latency, result, hold and release.
    task automatic finish(input int n, input int hold, input bit rdy_early);
        longint s = model_total(n);
        int cyc = 1;
        while (!out_valid_o && cyc < 20) begin
            chk("in_ready_drain", 64'(in_ready_o), 64'd0);
            tick();
            cyc++;
        end
        chk("out_latency", 64'(cyc), 64'd4);
        chk("loss", 64'(loss_o), 64'(model_loss(s)));
        chk("count", 64'(count_o), 64'(n));
        chk("ovf", 64'(ovf_o), 64'(model_ovf(s)));
        chk("in_ready_hold", 64'(in_ready_o), 64'd0);
        if (!rdy_early) begin
            for (int k = 0; k < hold; k++) begin
                tick();
                chk("hold_valid", 64'(out_valid_o), 64'd1);
                chk("hold_loss", 64'(loss_o), 64'(model_loss(s)));
                chk("hold_in_ready", 64'(in_ready_o), 64'd0);
            end
            out_ready_i = 1'b1;
        end
        tick();
        chk("released_valid", 64'(out_valid_o), 64'd0);
        chk("released_in_ready", 64'(in_ready_o), 64'd1);
        out_ready_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_in_ready", 64'(in_ready_o), 64'd1);
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_loss", 64'(loss_o), 64'd0);
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_ovf", 64'(ovf_o), 64'd0);
        rst_i = 1'b1;
        tick();

        // Full batch closed by count: 4+4+0+49.
        b_pred[0] = 23'd5; b_pred[1] = 23'd1; b_pred[2] = 23'd3; b_pred[3] = 23'd10;
        for (int i = 0; i < BATCH; i++) b_tgt[i] = 4'd3;
        send(4, 1'b0, 0);
        chk("t1_model", 64'(model_total(4)), 64'd57);
        finish(4, 0, 1'b0);

        // Negative prediction, batch closed early by last.
        b_pred[0] = 23'h7FFFFF; b_tgt[0] = 4'd2;
        send(1, 1'b1, 0);
        finish(1, 0, 1'b0);

        // Consumer stalls for 10 cycles in HOLD.
        b_pred[0] = 23'd9; b_tgt[0] = 4'd4;
        b_pred[1] = 23'h7FFFFE; b_tgt[1] = 4'd0;
        send(2, 1'b1, 1);
        finish(2, 10, 1'b0);

        // Overflow: 3 x 100 against an 8-bit accumulator.
        for (int i = 0; i < 3; i++) begin b_pred[i] = 23'd10; b_tgt[i] = 4'd0; end
        send(3, 1'b1, 0);
        finish(3, 2, 1'b0);

        // Flush during DRAIN: nothing is emitted, state is cleared.
        b_pred[0] = 23'd7; b_tgt[0] = 4'd1;
        b_pred[1] = 23'd6; b_tgt[1] = 4'd2;
        send(2, 1'b1, 0);
        clr_i = 1'b1;
        chk("clr_in_ready", 64'(in_ready_o), 64'd0);
        tick();
        clr_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("clr_no_valid", 64'(out_valid_o), 64'd0);
            tick();
        end
        chk("clr_count", 64'(count_o), 64'd0);
        chk("clr_ovf", 64'(ovf_o), 64'd0);
        chk("clr_loss", 64'(loss_o), 64'd0);
        chk("clr_in_ready_after", 64'(in_ready_o), 64'd1);
        b_pred[0] = 23'd2; b_tgt[0] = 4'd0;
        send(1, 1'b1, 0);
        finish(1, 1, 1'b0);

        // Asynchronous reset in the middle of an open batch.
        for (int i = 0; i < 3; i++) begin b_pred[i] = 23'd20; b_tgt[i] = 4'd0; end
        send(3, 1'b0, 0);
        repeat (3) tick();
        chk("pre_rst_count", 64'(count_o), 64'd3);
        chk("pre_rst_ovf", 64'(ovf_o), 64'(model_ovf(model_total(3))));
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_ovf", 64'(ovf_o), 64'd0);
        chk("arst_valid", 64'(out_valid_o), 64'd0);
        chk("arst_in_ready", 64'(in_ready_o), 64'd1);
        tick();
        rst_i = 1'b1;
        tick();
        b_pred[0] = 23'd1; b_tgt[0] = 4'd9;
        b_pred[1] = 23'h7FFFF0; b_tgt[1] = 4'd1;
        send(2, 1'b1, 0);
        finish(2, 0, 1'b0);

        // Randomized batches: mostly small errors, occasionally full-range predictions.
        for (int b = 0; b < 40; b++) begin
            int  n     = int'($urandom_range(1, BATCH));
            bit  last  = (n < BATCH) ? 1'b1 : bit'($urandom_range(0, 1));
            bit  early = bit'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 7) == 0)
                    b_pred[i] = PRED_W'($urandom);
                else
                    b_pred[i] = PRED_W'(int'($urandom_range(0, 24)) - 12);
                b_tgt[i] = TGT_W'($urandom);
            end
            out_ready_i = early;
            send(n, last, 2);
            finish(n, int'($urandom_range(0, 4)), early);
            repeat (int'($urandom_range(0, 2))) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
